// File: rtl/centrosym_matrix_inv_if.sv
// Handshake bundle for centrosym_matrix_inv: y-pair input stream and x-pair output stream.
// The master drives y, din_* and dout_ready; the slave (the transform block) drives the rest.
interface centrosym_matrix_inv_if #(
   parameter int unsigned DIN_WIDTH = 19
);
   logic signed [DIN_WIDTH-1:0] y1_re;
   logic signed [DIN_WIDTH-1:0] y1_im;
   logic signed [DIN_WIDTH-1:0] y2_re;
   logic signed [DIN_WIDTH-1:0] y2_im;
   logic                        din_last;
   logic                        din_valid;
   logic                        din_ready;
   logic signed [DIN_WIDTH-1:0] x1_re;
   logic signed [DIN_WIDTH-1:0] x1_im;
   logic signed [DIN_WIDTH-1:0] x2_re;
   logic signed [DIN_WIDTH-1:0] x2_im;
   logic                        dout_valid;
   logic                        dout_ready;
   logic                        dout_last;
   logic                        frame_err;

   modport master (
      output y1_re, y1_im, y2_re, y2_im, din_last, din_valid, dout_ready,
      input  din_ready, x1_re, x1_im, x2_re, x2_im, dout_valid, dout_last, frame_err
   );

   modport slave (
      input  y1_re, y1_im, y2_re, y2_im, din_last, din_valid, dout_ready,
      output din_ready, x1_re, x1_im, x2_re, x2_im, dout_valid, dout_last, frame_err
   );
endinterface

// File: rtl/centrosym_matrix_inv.sv
// Inverse unitary (centrosymmetric) pair transform x = Q*y:
//   x1 = (y1 + j*y2)/2, x2 = (y1 - j*y2)/2
// Elastic 2-stage valid/ready pipeline with a frame counter that flags the last pair of each
// VECTOR_LEN-pair vector and a sticky frame_err when the upstream din_last tag disagrees.
// Build option: define CENTROSYM_INV_ROUND_EN for round-half-up halving; otherwise the halving
// truncates toward -inf. Latency and handshake are the same in both builds.
module centrosym_matrix_inv #(
   parameter int unsigned DIN_WIDTH  = 19,
   parameter int unsigned VECTOR_LEN = 4
) (
   input logic                   clk,
   input logic                   rst,
   centrosym_matrix_inv_if.slave bus
);

   localparam int unsigned CntW = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(VECTOR_LEN - 1);

   typedef logic signed [DIN_WIDTH-1:0] din_t;
   typedef logic signed [DIN_WIDTH:0]   wide_t;

   // One extra bit of headroom so sums/differences of two full-scale inputs never wrap.
   function automatic wide_t ext(input din_t v);
      return {v[DIN_WIDTH-1], v};
   endfunction

   // Halve a widened sum back to DIN_WIDTH bits.
   function automatic din_t halve(input wide_t s);
`ifdef CENTROSYM_INV_ROUND_EN
      // +1 cannot overflow: the largest sum is 2^DIN_WIDTH-2.
      return din_t'((s + wide_t'(1)) >>> 1);
`else
      return din_t'(s >>> 1);
`endif
   endfunction

   // Stage 1 registers
   din_t y1_re_q, y1_im_q, y2_re_q, y2_im_q;
   logic last1_q, v1_q;

   // Stage 2 registers
   din_t x1_re_q, x1_im_q, x2_re_q, x2_im_q;
   logic last2_q, v2_q;

   // Framing state
   logic [CntW-1:0] cnt_q;
   logic            frame_err_q;

   logic e1, e2, out_xfer, cnt_at_max;
   din_t x1_re_d, x1_im_d, x2_re_d, x2_im_d;

   // Stage enables: a stage may load when it is empty or its contents move on this cycle.
   always_comb begin
      e2         = !v2_q || bus.dout_ready;
      e1         = !v1_q || e2;
      out_xfer   = v2_q && bus.dout_ready;
      cnt_at_max = (cnt_q == CntMax);
   end

   // Inverse pair transform on the stage-1 contents.
   always_comb begin
      x1_re_d = halve(ext(y1_re_q) - ext(y2_im_q));
      x1_im_d = halve(ext(y1_im_q) + ext(y2_re_q));
      x2_re_d = halve(ext(y1_re_q) + ext(y2_im_q));
      x2_im_d = halve(ext(y1_im_q) - ext(y2_re_q));
   end

   // Stage 1: capture the incoming pair and its din_last tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q    <= 1'b0;
         last1_q <= 1'b0;
         y1_re_q <= '0;
         y1_im_q <= '0;
         y2_re_q <= '0;
         y2_im_q <= '0;
      end else if (e1) begin
         v1_q    <= bus.din_valid;
         last1_q <= bus.din_last;
         y1_re_q <= bus.y1_re;
         y1_im_q <= bus.y1_im;
         y2_re_q <= bus.y2_re;
         y2_im_q <= bus.y2_im;
      end
   end

   // Stage 2: register the transformed pair; the tag travels alongside for the framing check.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_q    <= 1'b0;
         last2_q <= 1'b0;
         x1_re_q <= '0;
         x1_im_q <= '0;
         x2_re_q <= '0;
         x2_im_q <= '0;
      end else if (e2) begin
         v2_q    <= v1_q;
         last2_q <= last1_q;
         x1_re_q <= x1_re_d;
         x1_im_q <= x1_im_d;
         x2_re_q <= x2_re_d;
         x2_im_q <= x2_im_d;
      end
   end

   // Pair index within the vector; no resync on a tag mismatch, the error is just latched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         frame_err_q <= 1'b0;
      end else if (out_xfer) begin
         cnt_q <= cnt_at_max ? '0 : cnt_q + 1'b1;
         if (last2_q != cnt_at_max) begin
            frame_err_q <= 1'b1;
         end
      end
   end

   // Output drive.
   always_comb begin
      bus.din_ready  = e1;
      bus.dout_valid = v2_q;
      bus.dout_last  = v2_q && cnt_at_max;
      bus.frame_err  = frame_err_q;
      bus.x1_re      = x1_re_q;
      bus.x1_im      = x1_im_q;
      bus.x2_re      = x2_re_q;
      bus.x2_im      = x2_im_q;
   end

endmodule

// File: tb/tb_centrosym_matrix_inv.sv
// Bench for centrosym_matrix_inv: directed vector table, backpressure, framing, async reset
// and a randomized forward-then-inverse regression, all scored against an arithmetic model.
module tb_centrosym_matrix_inv;

   localparam int unsigned W  = 19;
   localparam int unsigned VL = 4;
`ifdef CENTROSYM_INV_ROUND_EN
   localparam bit Rnd = 1'b1;
`else
   localparam bit Rnd = 1'b0;
`endif

   typedef logic signed [W-1:0] d_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   centrosym_matrix_inv_if #(.DIN_WIDTH(W)) bus ();

   centrosym_matrix_inv #(
      .DIN_WIDTH (W),
      .VECTOR_LEN(VL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: exact halving of an integer, floor or round-half-up.
   function automatic longint halve(input longint s);
      longint t;
      t = Rnd ? s + 1 : s;
      if (t >= 0) return t / 2;
      return -((-t + 1) / 2);
   endfunction

   function automatic longint sx(input d_t v);
      return longint'(v);
   endfunction

   function automatic longint excess(input longint d);
      return (d >= -1 && d <= 1) ? 0 : d;
   endfunction

   typedef struct {
      longint x1r, x1i, x2r, x2i;
      logic   last;
      logic   has_orig;
      longint o1r, o1i, o2r, o2i;
   } exp_t;

   exp_t   exp_q[$];
   exp_t   e_in, e_out;
   longint out_idx    = 0;
   logic   model_err  = 1'b0;
   logic   prev_stall = 1'b0;
   int     n_out      = 0;
   longint cur_o[4];
   logic   cur_has_orig = 1'b0;

   // Scoreboard: samples on the falling edge, mid-way between input updates.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         out_idx    = 0;
         model_err  = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check("hold_valid", bus.dout_valid, 1);
         check("frame_err", bus.frame_err, model_err);
         if (bus.din_valid && bus.din_ready) begin
            e_in.x1r      = halve(sx(bus.y1_re) - sx(bus.y2_im));
            e_in.x1i      = halve(sx(bus.y1_im) + sx(bus.y2_re));
            e_in.x2r      = halve(sx(bus.y1_re) + sx(bus.y2_im));
            e_in.x2i      = halve(sx(bus.y1_im) - sx(bus.y2_re));
            e_in.last     = bus.din_last;
            e_in.has_orig = cur_has_orig;
            e_in.o1r      = cur_o[0];
            e_in.o1i      = cur_o[1];
            e_in.o2r      = cur_o[2];
            e_in.o2i      = cur_o[3];
            exp_q.push_back(e_in);
         end
         if (bus.dout_valid)
            check("dout_last", bus.dout_last, ((out_idx % longint'(VL)) == longint'(VL - 1)));
         if (bus.dout_valid && bus.dout_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", exp_q.size(), 1);
            end else begin
               e_out = exp_q.pop_front();
               check("x1_re", sx(bus.x1_re), e_out.x1r);
               check("x1_im", sx(bus.x1_im), e_out.x1i);
               check("x2_re", sx(bus.x2_re), e_out.x2r);
               check("x2_im", sx(bus.x2_im), e_out.x2i);
               if (e_out.has_orig) begin
                  check("recover_x1_re", excess(sx(bus.x1_re) - e_out.o1r), 0);
                  check("recover_x1_im", excess(sx(bus.x1_im) - e_out.o1i), 0);
                  check("recover_x2_re", excess(sx(bus.x2_re) - e_out.o2r), 0);
                  check("recover_x2_im", excess(sx(bus.x2_im) - e_out.o2i), 0);
               end
               if (e_out.last != ((out_idx % longint'(VL)) == longint'(VL - 1))) model_err = 1'b1;
            end
            out_idx++;
            n_out++;
         end
         prev_stall = bus.dout_valid && !bus.dout_ready;
      end
   end

   // Called just after a rising edge; returns just after the edge that accepted the pair.
   task automatic send(input longint a, input longint b, input longint c, input longint d,
                       input logic last);
      int   guard;
      logic acc;
      guard         = 0;
      bus.y1_re     = d_t'(a);
      bus.y1_im     = d_t'(b);
      bus.y2_re     = d_t'(c);
      bus.y2_im     = d_t'(d);
      bus.din_last  = last;
      bus.din_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = bus.din_ready;
         @(posedge clk);
         #1;
         guard++;
      end while (!acc && guard < 1000);
      if (!acc) check("din_accept_timeout", acc, 1);
      bus.din_valid = 1'b0;
   endtask

   task automatic drain(input int want_out, input int base);
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 500) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("drain_empty", exp_q.size(), 0);
      check("out_count", n_out - base, want_out);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      #1;
      check("rst_dout_valid", bus.dout_valid, 0);
      check("rst_dout_last", bus.dout_last, 0);
      check("rst_frame_err", bus.frame_err, 0);
      check("rst_x1_re", sx(bus.x1_re), 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_din_ready", bus.din_ready, 1);
   endtask

   typedef struct {
      string  name;
      longint y1r, y1i, y2r, y2i;
      longint x1r, x1i, x2r, x2i;
   } vec_t;

   vec_t tbl[6];
   logic stop_rnd;
   int   base;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{"basic",   10, 6, 4, -2,  6, 5, 4, 1};
      tbl[1] = '{"rnd_pos",  3, 0, 0, 0,  Rnd ? 2 : 1, 0, Rnd ? 2 : 1, 0};
      tbl[2] = '{"rnd_neg", -3, 0, 0, 0,  Rnd ? -1 : -2, 0, Rnd ? -1 : -2, 0};
      tbl[3] = '{"fs_pos", 262143, 0, 0, 262143,  0, 0, 262143, 0};
      tbl[4] = '{"fs_neg", -262144, 0, 0, -262144,  0, 0, -262144, 0};
      tbl[5] = '{"imag",     0, -5, 7, 0,  0, 1, 0, -6};

      bus.y1_re      = '0;
      bus.y1_im      = '0;
      bus.y2_re      = '0;
      bus.y2_im      = '0;
      bus.din_last   = 1'b0;
      bus.din_valid  = 1'b0;
      bus.dout_ready = 1'b1;
      cur_o          = '{0, 0, 0, 0};
      do_reset();

      // Directed vectors: single pairs, 2-cycle latency, one-cycle valid.
      for (int i = 0; i < 6; i++) begin
         send(tbl[i].y1r, tbl[i].y1i, tbl[i].y2r, tbl[i].y2i, (i % VL) == VL - 1);
         @(posedge clk);
         #1;
         check({tbl[i].name, "_valid"}, bus.dout_valid, 1);
         check({tbl[i].name, "_x1_re"}, sx(bus.x1_re), tbl[i].x1r);
         check({tbl[i].name, "_x1_im"}, sx(bus.x1_im), tbl[i].x1i);
         check({tbl[i].name, "_x2_re"}, sx(bus.x2_re), tbl[i].x2r);
         check({tbl[i].name, "_x2_im"}, sx(bus.x2_im), tbl[i].x2i);
         @(posedge clk);
         #1;
         check({tbl[i].name, "_valid_drop"}, bus.dout_valid, 0);
      end

      // Backpressure: 8 pairs back to back with a 5-cycle stall mid-burst.
      do_reset();
      base = n_out;
      fork
         begin
            for (int i = 0; i < 8; i++) send(i * 100 + 1, -i, i * 3, 7 - i, (i % VL) == VL - 1);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            bus.dout_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            check("bp_din_ready", bus.din_ready, 0);
            check("bp_dout_valid", bus.dout_valid, 1);
            bus.dout_ready = 1'b1;
         end
      join
      drain(8, base);

      // Framing: correct tags, then one tag moved from pair 3 to pair 5.
      do_reset();
      base = n_out;
      for (int i = 0; i < 12; i++) send(i, i + 1, -i, 2 * i, (i % 4) == 3);
      drain(12, base);
      check("frame_ok", bus.frame_err, 0);
      do_reset();
      base = n_out;
      for (int i = 0; i < 12; i++) send(i, -i, i, -i, (i == 5) || (i == 7) || (i == 11));
      drain(12, base);
      check("frame_bad", bus.frame_err, 1);
      for (int i = 0; i < 3; i++) send(i, i, i, i, 1'b0);
      drain(15, base);
      check("frame_sticky", bus.frame_err, 1);

      // Async reset with both stages full, then framing restarts at index 0.
      do_reset();
      bus.dout_ready = 1'b0;
      send(1, 2, 3, 4, 1'b0);
      send(5, 6, 7, 8, 1'b0);
      check("full_dout_valid", bus.dout_valid, 1);
      check("full_din_ready", bus.din_ready, 0);
      do_reset();
      bus.dout_ready = 1'b1;
      base = n_out;
      for (int i = 0; i < 4; i++) send(10 * i, i, -i, 3, i == 3);
      drain(4, base);
      check("post_rst_frame", bus.frame_err, 0);

      // Random regression: x -> forward Q^H -> this block, with random gaps and backpressure.
      do_reset();
      base     = n_out;
      stop_rnd = 1'b0;
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               longint o[4];
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               for (int k = 0; k < 4; k++) o[k] = longint'($urandom_range(0, 262143)) - 131072;
               cur_o        = o;
               cur_has_orig = 1'b1;
               // y1 = x1 + x2, y2 = -j(x1 - x2)
               send(o[0] + o[2], o[1] + o[3], o[1] - o[3], -(o[0] - o[2]), (i % VL) == VL - 1);
            end
            cur_has_orig = 1'b0;
            stop_rnd     = 1'b1;
         end
         begin
            while (!stop_rnd) begin
               @(posedge clk);
               #1;
               bus.dout_ready = ($urandom_range(0, 3) != 0);
            end
            bus.dout_ready = 1'b1;
         end
      join
      drain(200, base);
      check("rnd_frame", bus.frame_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
